// File: rtl/id_stage_pipe.sv
// ---------------------------------------------------------------------------
// id_stage_pipe: registered RV32I instruction-decode stage (IF/ID -> ID/EX).
//
// Decodes OP-IMM, OP, LOAD and STORE. Operands come from the GPR file or are
// forwarded from later stages, where the youngest stage (index 0) wins. A
// load-use hazard holds the input and inserts a bubble. Both sides use a
// valid/ready handshake, and flush_i kills the held operation and the input.
//
// Optional feature: define ID_LUI_AUIPC_EN to also decode LUI and AUIPC.
// Without it, both opcodes are reported as unknown (error_o=1).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; instr_i, pc_i are the instruction
//   flush_i             kill the held output and the current input
//   gprs_raddr1/2       combinational rs1/rs2 addresses to the GPR file
//   gprs_rdata1/2_i     asynchronous GPR read data
//   fwd_waddr_i/wdata_i flattened forwarding sources (index 0 = youngest)
//   fwd_isload_i        forwarding source is a load whose data is not ready
//   out_valid/out_ready output handshake
//   rtlop_o, rtltype_o  ALU operation and operation type
//   pc_o, src1_o, src2_o, store_data_o, gprs_waddr_o, error_o  ID/EX payload
// ---------------------------------------------------------------------------
module id_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               instr_i,
  input  logic [DATA_W-1:0]         pc_i,
  input  logic                      flush_i,
  output logic [REG_AW-1:0]         gprs_raddr1,
  output logic [REG_AW-1:0]         gprs_raddr2,
  input  logic [DATA_W-1:0]         gprs_rdata1_i,
  input  logic [DATA_W-1:0]         gprs_rdata2_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_isload_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3:0]                rtlop_o,
  output logic [1:0]                rtltype_o,
  output logic [DATA_W-1:0]         pc_o,
  output logic [DATA_W-1:0]         src1_o,
  output logic [DATA_W-1:0]         src2_o,
  output logic [DATA_W-1:0]         store_data_o,
  output logic [REG_AW-1:0]         gprs_waddr_o,
  output logic                      error_o
);

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [1:0] T_ARICH = 2'd0, T_RMEM = 2'd1, T_WMEM = 2'd2;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SHR = 4'b0101;
  localparam logic [3:0] OP_SAR = 4'b1101, OP_SUB = 4'b1000;

  // instruction fields
  logic [6:0]        w_opc, w_f7;
  logic [2:0]        w_f3;
  logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
  logic [DATA_W-1:0] w_imm_i, w_imm_s;

  assign w_opc   = instr_i[6:0];
  assign w_f3    = instr_i[14:12];
  assign w_f7    = instr_i[31:25];
  assign w_rd    = REG_AW'(instr_i[11:7]);
  assign w_rs1   = REG_AW'(instr_i[19:15]);
  assign w_rs2   = REG_AW'(instr_i[24:20]);
  assign w_imm_i = DATA_W'($signed(instr_i[31:20]));
  assign w_imm_s = DATA_W'($signed({instr_i[31:25], instr_i[11:7]}));

`ifdef ID_LUI_AUIPC_EN
  logic [DATA_W-1:0] w_imm_u;
  assign w_imm_u = DATA_W'($signed({instr_i[31:12], 12'b0}));
`endif

  assign gprs_raddr1 = w_rs1;
  assign gprs_raddr2 = w_rs2;

  // unpack the forwarding buses
  logic [REG_AW-1:0] w_fwd_addr [NUM_FWD];
  logic [DATA_W-1:0] w_fwd_data [NUM_FWD];
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
      assign w_fwd_addr[gi] = fwd_waddr_i[gi*REG_AW +: REG_AW];
      assign w_fwd_data[gi] = fwd_wdata_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Scan oldest to youngest so the youngest matching source is applied last
  // and wins. x0 overrides everything.
  logic [DATA_W-1:0] w_op1, w_op2;
  always_comb begin
    w_op1 = gprs_rdata1_i;
    w_op2 = gprs_rdata2_i;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (w_fwd_addr[k] != '0 && w_fwd_addr[k] == w_rs1) w_op1 = w_fwd_data[k];
      if (w_fwd_addr[k] != '0 && w_fwd_addr[k] == w_rs2) w_op2 = w_fwd_data[k];
    end
    if (w_rs1 == '0) w_op1 = '0;
    if (w_rs2 == '0) w_op2 = '0;
  end

  // decode
  logic              w_use1, w_use2, w_err;
  logic [3:0]        w_rtlop;
  logic [1:0]        w_rtltype;
  logic [DATA_W-1:0] w_src1, w_src2, w_store;
  logic [REG_AW-1:0] w_waddr;

  always_comb begin
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_err     = 1'b0;
    w_rtlop   = OP_ADD;
    w_rtltype = T_ARICH;
    w_src1    = '0;
    w_src2    = '0;
    w_store   = '0;
    w_waddr   = '0;
    case (w_opc)
      OPC_OPIMM: begin
        w_use1  = 1'b1;
        w_src1  = w_op1;
        w_src2  = w_imm_i;
        w_waddr = w_rd;
        w_rtlop = {1'b0, w_f3};
        if (w_f3 == 3'b101) begin
          if (w_f7 == F7_BASE)     w_rtlop = OP_SHR;
          else if (w_f7 == F7_ALT) w_rtlop = OP_SAR;
          else                     w_err   = 1'b1;
        end else if (w_f3 == 3'b001 && w_f7 != F7_BASE) begin
          w_err = 1'b1;
        end
      end
      OPC_OP: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_src1  = w_op1;
        w_src2  = w_op2;
        w_waddr = w_rd;
        w_rtlop = {1'b0, w_f3};
        if (w_f3 == 3'b000 || w_f3 == 3'b101) begin
          if (w_f7 == F7_ALT)       w_rtlop = (w_f3 == 3'b000) ? OP_SUB : OP_SAR;
          else if (w_f7 != F7_BASE) w_err   = 1'b1;
        end else if (w_f7 != F7_BASE) begin
          w_err = 1'b1;
        end
      end
      OPC_LOAD: begin
        w_use1    = 1'b1;
        w_src1    = w_op1;
        w_src2    = w_imm_i;
        w_rtltype = T_RMEM;
        w_waddr   = w_rd;
      end
      OPC_STORE: begin
        w_use1    = 1'b1;
        w_use2    = 1'b1;
        w_src1    = w_op1;
        w_src2    = w_imm_s;
        w_store   = w_op2;
        w_rtltype = T_WMEM;
      end
`ifdef ID_LUI_AUIPC_EN
      7'b0110111: begin
        w_src2  = w_imm_u;
        w_waddr = w_rd;
      end
      7'b0010111: begin
        w_src1  = pc_i;
        w_src2  = w_imm_u;
        w_waddr = w_rd;
      end
`endif
      default: w_err = 1'b1;
    endcase
    if (w_err) w_waddr = '0;
  end

  // load-use hazard: a pending load targets a source this instruction reads
  logic w_hazard;
  always_comb begin
    w_hazard = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (fwd_isload_i[k] && w_fwd_addr[k] != '0 &&
          ((w_use1 && w_fwd_addr[k] == w_rs1) || (w_use2 && w_fwd_addr[k] == w_rs2)))
        w_hazard = 1'b1;
    end
  end

  assign in_ready = (~out_valid | out_ready) & ~w_hazard & ~flush_i;

  // ID/EX register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      rtlop_o      <= '0;
      rtltype_o    <= T_ARICH;
      pc_o         <= '0;
      src1_o       <= '0;
      src2_o       <= '0;
      store_data_o <= '0;
      gprs_waddr_o <= '0;
      error_o      <= 1'b0;
    end else if (flush_i) begin
      // a killed operation must neither write back nor trap
      out_valid    <= 1'b0;
      gprs_waddr_o <= '0;
      error_o      <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (in_valid && !w_hazard) begin
        out_valid    <= 1'b1;
        rtlop_o      <= w_rtlop;
        rtltype_o    <= w_rtltype;
        pc_o         <= pc_i;
        src1_o       <= w_src1;
        src2_o       <= w_src2;
        store_data_o <= w_store;
        gprs_waddr_o <= w_waddr;
        error_o      <= w_err;
      end else begin
        // bubble (no input or load-use hazard)
        out_valid    <= 1'b0;
        gprs_waddr_o <= '0;
        error_o      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_stage_pipe: directed self-checking bench for id_stage_pipe.
// A small GPR array answers the DUT's combinational read addresses; all
// expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush_i, out_valid, out_ready, error_o;
  logic [31:0] instr_i, pc_i;
  logic [4:0]  gprs_raddr1, gprs_raddr2, gprs_waddr_o;
  logic [31:0] gprs_rdata1_i, gprs_rdata2_i;
  logic [9:0]  fwd_waddr_i;
  logic [63:0] fwd_wdata_i;
  logic [1:0]  fwd_isload_i;
  logic [3:0]  rtlop_o;
  logic [1:0]  rtltype_o;
  logic [31:0] pc_o, src1_o, src2_o, store_data_o;

  logic [31:0] gpr [32];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign gprs_rdata1_i = gpr[gprs_raddr1];
  assign gprs_rdata2_i = gpr[gprs_raddr2];

  id_stage_pipe #(.DATA_W(32), .REG_AW(5), .NUM_FWD(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i),
    .gprs_raddr1(gprs_raddr1), .gprs_raddr2(gprs_raddr2),
    .gprs_rdata1_i(gprs_rdata1_i), .gprs_rdata2_i(gprs_rdata2_i),
    .fwd_waddr_i(fwd_waddr_i), .fwd_wdata_i(fwd_wdata_i), .fwd_isload_i(fwd_isload_i),
    .out_valid(out_valid), .out_ready(out_ready), .rtlop_o(rtlop_o),
    .rtltype_o(rtltype_o), .pc_o(pc_o), .src1_o(src1_o), .src2_o(src2_o),
    .store_data_o(store_data_o), .gprs_waddr_o(gprs_waddr_o), .error_o(error_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int k, input logic [4:0] a, input logic [31:0] d, input logic ld);
    fwd_waddr_i[k*5 +: 5]   = a;
    fwd_wdata_i[k*32 +: 32] = d;
    fwd_isload_i[k]         = ld;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_rtlop"}, 32'(rtlop_o), 32'd0);
    chk({tag, "_rtltype"}, 32'(rtltype_o), 32'd0);
    chk({tag, "_pc"}, pc_o, 32'd0);
    chk({tag, "_src1"}, src1_o, 32'd0);
    chk({tag, "_src2"}, src2_o, 32'd0);
    chk({tag, "_sdata"}, store_data_o, 32'd0);
    chk({tag, "_waddr"}, 32'(gprs_waddr_o), 32'd0);
    chk({tag, "_err"}, 32'(error_o), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) gpr[i] = 32'h1000 + 32'(i);
    gpr[0] = 32'h77;  // garbage on x0: the DUT must still read 0
    gpr[1] = 32'd7;  gpr[2] = 32'd3;  gpr[5] = 32'hAA;  gpr[6] = 32'h200;
    rst_n = 1'b0; in_valid = 1'b0; instr_i = '0; pc_i = '0; flush_i = 1'b0;
    out_ready = 1'b1; fwd_waddr_i = '0; fwd_wdata_i = '0; fwd_isload_i = '0;
    #12;
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);

    // addi x1,x0,5
    in_valid = 1'b1; instr_i = 32'h00500093; pc_i = 32'h100;
    tick();
    $display("txn addi  valid=%0d src1=%0h src2=%0h waddr=%0d", out_valid, src1_o, src2_o, gprs_waddr_o);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_rtlop", 32'(rtlop_o), 32'd0);
    chk("addi_src1", src1_o, 32'd0);
    chk("addi_src2", src2_o, 32'd5);
    chk("addi_waddr", 32'(gprs_waddr_o), 32'd1);
    chk("addi_pc", pc_o, 32'h100);

    // add x3,x1,x2: both sources hold x1, youngest (0) wins
    instr_i = 32'h002081B3; pc_i = 32'h104;
    set_fwd(0, 5'd1, 32'd9, 1'b0); set_fwd(1, 5'd1, 32'd4, 1'b0);
    tick();
    $display("txn add   src1=%0h src2=%0h waddr=%0d", src1_o, src2_o, gprs_waddr_o);
    chk("add_src1", src1_o, 32'd9);
    chk("add_src2", src2_o, 32'd3);
    chk("add_waddr", 32'(gprs_waddr_o), 32'd3);

    // add x5,x0,x2: x0 reads 0; only older source matches x2
    instr_i = 32'h002002B3; pc_i = 32'h108;
    set_fwd(0, 5'd0, 32'd99, 1'b0); set_fwd(1, 5'd2, 32'h55, 1'b0);
    tick();
    $display("txn addx0 src1=%0h src2=%0h", src1_o, src2_o);
    chk("x0_src1", src1_o, 32'd0);
    chk("old_fwd_src2", src2_o, 32'h55);

    // sub x4,x2,x1 with a pending load to x2
    instr_i = 32'h40110233; pc_i = 32'h10C;
    set_fwd(0, 5'd2, 32'h20, 1'b1); set_fwd(1, 5'd0, 32'd0, 1'b0);
    #1;
    chk("haz_in_ready", 32'(in_ready), 32'd0);
    tick();
    $display("txn bubble valid=%0d waddr=%0d", out_valid, gprs_waddr_o);
    chk("bubble_valid", 32'(out_valid), 32'd0);
    chk("bubble_waddr", 32'(gprs_waddr_o), 32'd0);
    set_fwd(0, 5'd2, 32'h20, 1'b0);
    #1;
    chk("nohaz_in_ready", 32'(in_ready), 32'd1);
    tick();
    $display("txn sub   rtlop=%0h src1=%0h src2=%0h", rtlop_o, src1_o, src2_o);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_rtlop", 32'(rtlop_o), 32'b1000);
    chk("sub_src1", src1_o, 32'h20);
    chk("sub_src2", src2_o, 32'd7);
    chk("sub_waddr", 32'(gprs_waddr_o), 32'd4);

    // srai x8,x1,2: rs2 field is x2 but unused, so the pending load is harmless
    instr_i = 32'h4020D413; pc_i = 32'h110;
    set_fwd(0, 5'd2, 32'h20, 1'b1);
    #1;
    chk("srai_in_ready", 32'(in_ready), 32'd1);
    tick();
    $display("txn srai  rtlop=%0h src1=%0h src2=%0h", rtlop_o, src1_o, src2_o);
    chk("srai_rtlop", 32'(rtlop_o), 32'b1101);
    chk("srai_src1", src1_o, 32'd7);
    chk("srai_src2", src2_o, 32'h402);
    chk("srai_waddr", 32'(gprs_waddr_o), 32'd8);

    // stall for 3 cycles with sw x5,-4(x6) waiting
    set_fwd(0, 5'd0, 32'd0, 1'b0);
    out_ready = 1'b0; instr_i = 32'hFE532E23; pc_i = 32'h114;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
      $display("txn stall%0d valid=%0d pc=%0h", c, out_valid, pc_o);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_pc", pc_o, 32'h110);
      chk("stall_src2", src2_o, 32'h402);
      chk("stall_waddr", 32'(gprs_waddr_o), 32'd8);
    end
    out_ready = 1'b1;
    tick();
    $display("txn sw    type=%0d src1=%0h src2=%0h sd=%0h", rtltype_o, src1_o, src2_o, store_data_o);
    chk("sw_type", 32'(rtltype_o), 32'd2);
    chk("sw_rtlop", 32'(rtlop_o), 32'd0);
    chk("sw_src1", src1_o, 32'h200);
    chk("sw_src2", src2_o, 32'hFFFFFFFC);
    chk("sw_sdata", store_data_o, 32'hAA);
    chk("sw_waddr", 32'(gprs_waddr_o), 32'd0);

    // illegal srai (funct7=0x01)
    instr_i = 32'h0230D393; pc_i = 32'h118;
    tick();
    $display("txn badsr err=%0d waddr=%0d", error_o, gprs_waddr_o);
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_err", 32'(error_o), 32'd1);
    chk("ill_waddr", 32'(gprs_waddr_o), 32'd0);

    // lui x1,0x12345
    instr_i = 32'h123450B7; pc_i = 32'h11C;
    tick();
    $display("txn lui   err=%0d src2=%0h waddr=%0d", error_o, src2_o, gprs_waddr_o);
    chk("lui_valid", 32'(out_valid), 32'd1);
`ifdef ID_LUI_AUIPC_EN
    chk("lui_err", 32'(error_o), 32'd0);
    chk("lui_src2", src2_o, 32'h12345000);
    chk("lui_waddr", 32'(gprs_waddr_o), 32'd1);
`else
    chk("lui_err", 32'(error_o), 32'd1);
    chk("lui_waddr", 32'(gprs_waddr_o), 32'd0);
`endif

    // flush kills the held op and refuses the input
    instr_i = 32'h00500093; pc_i = 32'h120; flush_i = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    $display("txn flush valid=%0d", out_valid);
    chk("flush_valid", 32'(out_valid), 32'd0);
    flush_i = 1'b0;
    tick();
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_pc", pc_o, 32'h120);

    // asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    $display("txn areset valid=%0d pc=%0h", out_valid, pc_o);
    chk_zero("areset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Registered instruction-decode stage for the RV32I core, sitting between the IF/ID buffer and the EX stage.
- Decodes OP-IMM, OP, LOAD and STORE instructions and selects operands.
- Forwards results from up to NUM_FWD later pipeline stages, with the youngest stage taking priority.
- Detects load-use hazards and inserts a bubble; uses a valid/ready handshake on both sides, with a flush input.

Parameters:
- DATA_W, 32, width of data, PC and immediates.
- REG_AW, 5, GPR address width.
- NUM_FWD, 2, number of forwarding sources. Index 0 is the youngest (EX), index NUM_FWD-1 the oldest.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  IF presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- instr_i  in  32  instruction word.
- pc_i  in  DATA_W  instruction PC.
- flush_i  in  1  kill the held output and the current input.
- gprs_raddr1  out  REG_AW  combinational rs1 address to the GPR file.
- gprs_raddr2  out  REG_AW  combinational rs2 address to the GPR file.
- gprs_rdata1_i  in  DATA_W  asynchronous read data for rs1.
- gprs_rdata2_i  in  DATA_W  asynchronous read data for rs2.
- fwd_waddr_i  in  NUM_FWD*REG_AW  flattened destination addresses of the forwarding sources.
- fwd_wdata_i  in  NUM_FWD*DATA_W  flattened result data of the forwarding sources.
- fwd_isload_i  in  NUM_FWD  source is a load whose data is not yet valid.
- out_valid  out  1  ID/EX register holds a valid operation.
- out_ready  in  1  EX consumes the operation.
- rtlop_o  out  4  ALU operation.
- rtltype_o  out  2  operation type.
- pc_o  out  DATA_W  PC of the operation.
- src1_o  out  DATA_W  first operand.
- src2_o  out  DATA_W  second operand.
- store_data_o  out  DATA_W  data to write for a store.
- gprs_waddr_o  out  REG_AW  destination register.
- error_o  out  1  illegal instruction flag, registered with the operation.

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs are 0; out_valid=0; rtltype_o=ARICH(0); gprs_waddr_o=x0.
- Held outputs stay at these values until the first accepted instruction.
- Output register update: loads when out_valid=0 or out_ready=1. Otherwise all outputs hold stable.
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush_i.
- Latency: an instruction accepted in cycle N appears at the outputs in cycle N+1.
- Forwarding, per operand:
  - Scan the sources from index 0 upward.
  - The first source with waddr != 0 and waddr == raddr supplies the data; otherwise the GPR read data is used.
  - An operand reading x0 is always 0.
- hazard: asserted when any fwd_isload_i[k] is set, its waddr != 0, and its waddr matches a source register the instruction uses.
  - Used sources: rs1 for all groups; rs2 for OP and STORE.
  - On hazard with a free output register, load a bubble: out_valid=0, gprs_waddr_o=0.
- flush_i: next edge sets out_valid=0. The input is not accepted. Flush has priority over hazard and over load.
- rtlop encoding:
  - {1'b0,funct3} for ADD/SLL/SLT/SLTU/XOR/OR/AND.
  - SHR=4'b0101, SAR=4'b1101, SUB=4'b1000.
- rtltype encoding: ARICH=0, RMEM=1, WMEM=2.
- OP-IMM (0010011):
  - src2 = sign-extended I-immediate; rd written.
  - funct3=101 requires funct7 0000000 (SHR) or 0100000 (SAR); any other funct7 sets error.
  - funct3=001 requires funct7 0000000.
- OP (0110011):
  - funct3=000: funct7 0000000 gives ADD, 0100000 gives SUB.
  - funct3=101: funct7 0000000 gives SHR, 0100000 gives SAR.
  - Other funct3 require funct7=0000000.
  - Any illegal funct7 sets error.
- LOAD (0000011): src1 = rs1, src2 = I-immediate, RMEM, ADD, rd written.
- STORE (0100011):
  - src1 = rs1, src2 = S-immediate, store_data = forwarded rs2; WMEM, ADD; waddr = 0.
- Unknown opcode: error_o=1, waddr=0, out_valid=1. The control unit traps on error_o.
- Any error forces gprs_waddr_o=0.
- Addition wraps modulo 2^DATA_W.

Optional Feature:
- ID_LUI_AUIPC_EN defined: also decodes the following, both with ARICH, ADD, rd written:
  - LUI (0110111): src1=0, src2={imm[31:12],12'b0}.
  - AUIPC (0010111): src1=pc_i, src2 = U-immediate.
- ID_LUI_AUIPC_EN undefined: both opcodes raise error_o as unknown opcodes.

Test Plan:
- addi x1,x0,5 (0x00500093), pc=0x100 -> next cycle: out_valid=1, rtlop=0, src1=0, src2=5, waddr=1, pc_o=0x100.
- add x3,x1,x2 with GPR x1=7, fwd[0]={x1,9}, fwd[1]={x1,4}, x2=3 -> src1=9 (youngest wins), src2=3, waddr=3.
- fwd[0]={x2,isload=1}; sub x4,x2,x1 -> in_ready=0 and a bubble for one cycle. Drop isload -> issued with rtlop=4'b1000.
- out_ready=0 for 3 cycles while out_valid=1 -> all outputs are stable and in_ready=0. Then out_ready=1 -> the next instruction loads.
- sw x5,-4(x6) with x6=0x200, x5=0xAA -> rtltype=2, src1=0x200, src2=0xFFFFFFFC, store_data=0xAA, waddr=0.
- Illegal srai with funct7=0x01 -> error_o=1, waddr=0. Assert flush_i -> out_valid=0 next cycle. rst_n low mid-stall -> all outputs 0 immediately.
